mq_server: RTL and testbench

Multi-channel queue server: arbitrates among `CH` per-channel queue-depth inputs, offers one channel at a time to the downstream consumer and, once enabled, streams a burst while counting the remaining length down on `pkt_len`. It generalises the single-queue server to `CH` channels with selectable arbitration and an optional burst cap. It sits between the per-channel queue-depth trackers and the shared output datapath; `bool_go` gates the datapath read.

---
 rtl/mq_server.sv | 111 +++++++++++
 tb/tb_mq_server.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mq_server.sv
// Multi-channel queue server: picks one non-empty channel, offers it downstream,
// then streams a burst of the latched length while counting pkt_len down.
//
// state | meaning
// IDLE  | scanning channel depths for a winner
// OFFER | winner and length latched, waiting for ena_n low
// SERVE | one word per cycle, pkt_len counts down to 1
// DONE  | one-cycle burst_done, round-robin pointer advances
module mq_server #(
  parameter int          CH        = 4,
  parameter int          LW        = 8,
  parameter int          MAX_BURST = 16,
  parameter logic [1:0]  MODE      = 2'b11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CH*LW-1:0]       cur_value,
  input  logic                   ena_n,
  output logic                   bool_ready,
  output logic                   bool_go,
  output logic [CH-1:0]          grant,
  output logic [$clog2(CH)-1:0]  grant_idx,
  output logic [LW-1:0]          pkt_len,
  output logic                   burst_done
);

  localparam int IW = $clog2(CH);

  typedef enum logic [1:0] {IDLE, OFFER, SERVE, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [CH-1:0]   req;
  logic            any_req;
  logic            found;
  int              start;
  logic [IW-1:0]   win_idx;
  logic [LW-1:0]   win_depth;
  logic [LW-1:0]   win_len;

  always_comb begin
    req = '0;
    for (int i = 0; i < CH; i++) begin
      req[i] = (cur_value[i*LW +: LW] != '0);
    end
    any_req = |req;
  end

  // Fixed priority is round-robin with the scan always starting at channel 0.
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    start   = MODE[0] ? int'(rr_ptr) : 0;
    for (int k = 0; k < CH; k++) begin
      if (!found && req[(start + k) % CH]) begin
        found   = 1'b1;
        win_idx = IW'((start + k) % CH);
      end
    end
    win_depth = cur_value[int'(win_idx)*LW +: LW];
    win_len   = (MODE[1] && (win_depth > LW'(MAX_BURST))) ? LW'(MAX_BURST) : win_depth;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = OFFER;
      OFFER:   if (!ena_n) state_nxt = SERVE;
      SERVE:   if (pkt_len <= LW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      grant_idx  <= '0;
      pkt_len    <= '0;
      rr_ptr     <= '0;
      bool_ready <= 1'b0;
      bool_go    <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      bool_ready <= (state_nxt == OFFER);
      bool_go    <= (state_nxt == SERVE);
      burst_done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= CH'(1) << win_idx;
            grant_idx <= win_idx;
            pkt_len   <= win_len;
          end
        end
        SERVE: begin
          if (pkt_len != '0) pkt_len <= pkt_len - 1'b1;
        end
        DONE: begin
          grant     <= '0;
          grant_idx <= '0;
          if (MODE[0]) rr_ptr <= (grant_idx == IW'(CH-1)) ? '0 : grant_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mq_server.sv
// Bench for mq_server: three instances (RR+cap, RR uncapped, fixed+cap) with a
// beat scoreboard; each task pushes expected beats and drains them after the burst.
module tb_mq_server;
  localparam int CH = 4;
  localparam int LW = 8;
  typedef logic [CH+2+LW-1:0] beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena_n = 1'b1;
  logic [CH*LW-1:0] cv_a = '0, cv_b = '0, cv_c = '0;

  logic a_ready, a_go, a_done, b_ready, b_go, b_done, c_ready, c_go, c_done;
  logic [CH-1:0] a_grant, b_grant, c_grant;
  logic [1:0]    a_idx, b_idx, c_idx;
  logic [LW-1:0] a_len, b_len, c_len;

  int compared = 0;
  int mismatched = 0;
  beat_t exp_a[$], obs_a[$], exp_b[$], obs_b[$], exp_c[$], obs_c[$];
  int n_done_a = 0, n_done_b = 0, n_done_c = 0, n_rdy_a = 0, n_go_a = 0, viol = 0;
  logic rst_q = 1'b1;
  logic pgo_a = 1'b0, pgo_b = 1'b0, pgo_c = 1'b0;

  mq_server #(.CH(CH), .LW(LW), .MAX_BURST(16), .MODE(2'b11)) u_a (
    .clk(clk), .rst(rst), .cur_value(cv_a), .ena_n(ena_n),
    .bool_ready(a_ready), .bool_go(a_go), .grant(a_grant), .grant_idx(a_idx),
    .pkt_len(a_len), .burst_done(a_done));
  mq_server #(.CH(CH), .LW(LW), .MAX_BURST(16), .MODE(2'b01)) u_b (
    .clk(clk), .rst(rst), .cur_value(cv_b), .ena_n(ena_n),
    .bool_ready(b_ready), .bool_go(b_go), .grant(b_grant), .grant_idx(b_idx),
    .pkt_len(b_len), .burst_done(b_done));
  mq_server #(.CH(CH), .LW(LW), .MAX_BURST(16), .MODE(2'b10)) u_c (
    .clk(clk), .rst(rst), .cur_value(cv_c), .ena_n(ena_n),
    .bool_ready(c_ready), .bool_go(c_go), .grant(c_grant), .grant_idx(c_idx),
    .pkt_len(c_len), .burst_done(c_done));

  always #5 clk = ~clk;

  always @(posedge clk) rst_q <= rst;

  function automatic int bad_proto(logic r, logic g, logic d, logic pg, logic rq);
    if ((r && g) || (d && (r || g)) || (d && !pg)) return 1;
    if (pg && !g && !d && !rq) return 1;
    return 0;
  endfunction

  function automatic beat_t mk(int ch, int l);
    beat_t b;
    b[CH+2+LW-1:2+LW] = CH'(1 << ch);
    b[LW+1:LW]        = 2'(ch);
    b[LW-1:0]         = LW'(l);
    return b;
  endfunction

  // Observed beats and protocol sanity are collected on the falling edge.
  always @(negedge clk) begin
    if (a_go) begin obs_a.push_back({a_grant, a_idx, a_len}); n_go_a++; end
    if (b_go) obs_b.push_back({b_grant, b_idx, b_len});
    if (c_go) obs_c.push_back({c_grant, c_idx, c_len});
    if (a_ready) n_rdy_a++;
    if (a_done) n_done_a++;
    if (b_done) n_done_b++;
    if (c_done) n_done_c++;
    viol += bad_proto(a_ready, a_go, a_done, pgo_a, rst_q);
    viol += bad_proto(b_ready, b_go, b_done, pgo_b, rst_q);
    viol += bad_proto(c_ready, c_go, c_done, pgo_c, rst_q);
    pgo_a = a_go;
    pgo_b = b_go;
    pgo_c = c_go;
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    int t;
    int bad;
    step; step;
    compared++;
    if ({a_ready, a_go, a_grant, a_idx, a_len, a_done, b_ready, b_go, b_grant, b_len,
         c_ready, c_go, c_grant, c_len} !== '0) begin
      mismatched++; $display("FAIL reset_init: a outputs %h, required 0", {a_ready, a_go, a_grant, a_len});
    end
    rst = 1'b0; cv_a[0 +: LW] = 8'd5; ena_n = 1'b0;
    t = 0;
    while (!a_go && t < 20) begin step; t++; end
    compared++;
    if (!a_go) begin mismatched++; $display("FAIL reset_traffic: bool_go %b, required 1", a_go); end
    step;
    rst = 1'b1;
    step;
    compared++;
    if ({a_ready, a_go, a_grant, a_idx, a_len, a_done} !== '0) begin
      mismatched++; $display("FAIL reset_mid: outputs %h, required 0", {a_ready, a_go, a_grant, a_idx, a_len, a_done});
    end
    step;
    compared++;
    if ({a_ready, a_go, a_grant, a_idx, a_len, a_done} !== '0) begin
      mismatched++; $display("FAIL reset_hold: outputs %h, required 0", {a_ready, a_go, a_grant, a_idx, a_len, a_done});
    end
    rst = 1'b0; cv_a = '0;
    bad = 0;
    repeat (5) begin
      step;
      if ({a_ready, a_go, a_grant, a_idx, a_len, a_done} !== '0) bad++;
    end
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL reset_idle: %0d nonzero cycles, required 0", bad); end
    compared++;
    if (n_done_a != 0) begin mismatched++; $display("FAIL reset_no_done: %0d pulses, required 0", n_done_a); end
    obs_a.delete();
  endtask

  task automatic test_single;
    int t;
    beat_t e, o;
    n_rdy_a = 0; n_done_a = 0; obs_a.delete();
    cv_a[2*LW +: LW] = 8'd4; ena_n = 1'b0;
    for (int l = 4; l >= 1; l--) exp_a.push_back(mk(2, l));
    step;
    compared++;
    if ({a_ready, a_grant, a_idx, a_len} !== {1'b1, 4'b0100, 2'd2, 8'd4}) begin
      mismatched++; $display("FAIL single_offer: got %h, required %h", {a_ready, a_grant, a_idx, a_len}, {1'b1, 4'b0100, 2'd2, 8'd4});
    end
    cv_a = '0;
    t = 0;
    while (n_done_a == 0 && t < 30) begin step; t++; end
    compared++;
    if ({a_go, a_ready, a_done, a_len} !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
      mismatched++; $display("FAIL single_done: got %h, required %h", {a_go, a_ready, a_done, a_len}, {3'b001, 8'd0});
    end
    compared++;
    if (n_rdy_a != 1) begin mismatched++; $display("FAIL single_ready_cycles: got %0d, required 1", n_rdy_a); end
    step;
    compared++;
    if ({a_ready, a_grant, a_idx, a_done} !== '0) begin
      mismatched++; $display("FAIL single_idle: got %h, required 0", {a_ready, a_grant, a_idx, a_done});
    end
    compared++;
    if (obs_a.size() != exp_a.size()) begin
      mismatched++; $display("FAIL single_beats: got %0d beats, required %0d", obs_a.size(), exp_a.size());
    end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL single_beat: got %h, required %h", o, e); end
    end
    exp_a.delete(); obs_a.delete();
  endtask

  task automatic test_cap;
    int t;
    beat_t e, o;
    n_done_a = 0; n_done_b = 0; obs_a.delete(); obs_b.delete();
    cv_a[0 +: LW] = 8'd40; cv_b[0 +: LW] = 8'd40; ena_n = 1'b0;
    for (int l = 16; l >= 1; l--) exp_a.push_back(mk(0, l));
    for (int l = 40; l >= 1; l--) exp_b.push_back(mk(0, l));
    step;
    compared++;
    if ({a_len, b_len} !== {8'd16, 8'd40}) begin
      mismatched++; $display("FAIL cap_offer: lens %0d/%0d, required 16/40", a_len, b_len);
    end
    cv_a = '0; cv_b = '0;
    t = 0;
    while ((n_done_a == 0 || n_done_b == 0) && t < 100) begin step; t++; end
    compared++;
    if (obs_a.size() != 16 || obs_b.size() != 40) begin
      mismatched++; $display("FAIL cap_beats: got %0d/%0d, required 16/40", obs_a.size(), obs_b.size());
    end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL cap_beat_a: got %h, required %h", o, e); end
    end
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      e = exp_b.pop_front(); o = obs_b.pop_front(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL cap_beat_b: got %h, required %h", o, e); end
    end
    exp_a.delete(); obs_a.delete(); exp_b.delete(); obs_b.delete();
    step; step;
  endtask

  task automatic test_rr;
    int t;
    int seq[5] = '{0, 1, 2, 3, 0};
    beat_t e, o;
    rst = 1'b1; step; rst = 1'b0;
    n_done_a = 0; obs_a.delete();
    cv_a = {4{8'd2}}; ena_n = 1'b0;
    foreach (seq[i]) begin
      exp_a.push_back(mk(seq[i], 2));
      exp_a.push_back(mk(seq[i], 1));
    end
    t = 0;
    while (n_done_a < 5 && t < 200) begin step; t++; end
    cv_a = '0;
    compared++;
    if (obs_a.size() != 10) begin mismatched++; $display("FAIL rr_beats: got %0d, required 10", obs_a.size()); end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL rr_beat: got %h, required %h", o, e); end
    end
    exp_a.delete(); obs_a.delete();
    step; step; step;
  endtask

  task automatic test_fixed;
    int t;
    beat_t e, o;
    n_done_c = 0; obs_c.delete();
    cv_c[1*LW +: LW] = 8'd3; cv_c[3*LW +: LW] = 8'd3; ena_n = 1'b0;
    repeat (3) for (int l = 3; l >= 1; l--) exp_c.push_back(mk(1, l));
    t = 0;
    while (n_done_c < 3 && t < 100) begin step; t++; end
    cv_c = '0;
    compared++;
    if (obs_c.size() != 9) begin mismatched++; $display("FAIL fixed_beats: got %0d, required 9", obs_c.size()); end
    while (exp_c.size() > 0 && obs_c.size() > 0) begin
      e = exp_c.pop_front(); o = obs_c.pop_front(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL fixed_beat: got %h, required %h", o, e); end
    end
    exp_c.delete(); obs_c.delete();
    step; step; step;
  endtask

  task automatic test_hold;
    int t;
    int bad;
    beat_t e, o;
    n_done_a = 0; obs_a.delete();
    ena_n = 1'b1; cv_a[1*LW +: LW] = 8'd5;
    for (int l = 5; l >= 1; l--) exp_a.push_back(mk(1, l));
    step;
    cv_a = '0;
    bad = 0;
    repeat (10) begin
      if (!(a_ready && !a_go && a_grant == 4'b0010 && a_len == 8'd5)) bad++;
      step;
    end
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL hold_offer: %0d bad cycles, required 0", bad); end
    ena_n = 1'b0;
    t = 0;
    while (n_done_a == 0 && t < 30) begin step; t++; end
    compared++;
    if (obs_a.size() != 5) begin mismatched++; $display("FAIL hold_beats: got %0d, required 5", obs_a.size()); end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL hold_beat: got %h, required %h", o, e); end
    end
    exp_a.delete(); obs_a.delete();
    step; step;
  endtask

  task automatic test_abort;
    int t;
    int bad;
    beat_t e, o;
    n_done_a = 0; n_go_a = 0; obs_a.delete();
    cv_a[2*LW +: LW] = 8'd6; ena_n = 1'b0;
    for (int l = 6; l >= 4; l--) exp_a.push_back(mk(2, l));
    t = 0;
    while (n_go_a < 3 && t < 30) begin step; t++; end
    rst = 1'b1; cv_a = '0;
    step;
    compared++;
    if ({a_ready, a_go, a_grant, a_idx, a_len, a_done} !== '0) begin
      mismatched++; $display("FAIL abort_reset: outputs %h, required 0", {a_ready, a_go, a_grant, a_idx, a_len, a_done});
    end
    rst = 1'b0;
    bad = 0;
    repeat (5) begin
      step;
      if ({a_ready, a_go, a_grant, a_idx, a_len, a_done} !== '0) bad++;
    end
    compared++;
    if (bad != 0 || n_done_a != 0) begin
      mismatched++; $display("FAIL abort_no_done: %0d busy cycles, %0d pulses, required 0/0", bad, n_done_a);
    end
    compared++;
    if (obs_a.size() != 3) begin mismatched++; $display("FAIL abort_beats: got %0d, required 3", obs_a.size()); end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front(); compared++;
      if (o !== e) begin mismatched++; $display("FAIL abort_beat: got %h, required %h", o, e); end
    end
    exp_a.delete(); obs_a.delete();
  endtask

  task automatic test_protocol;
    compared++;
    if (viol != 0) begin mismatched++; $display("FAIL protocol: %0d violations, required 0", viol); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_cap;
    test_rr;
    test_fixed;
    test_hold;
    test_abort;
    test_protocol;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
